// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg: definitions shared by the serial transmit feeder and the downstream
// shift-register / counter stages.
//   state_e     : FSM encoding of the transmit stage (ST_IDLE, ST_SHIFT)
//   SER_DATA_W  : default word width used across the serial datapath
//   SER_DIV     : default clk_en period in clk cycles
//   even_parity : XOR reduction helper (zero-extended input up to 64 bits)
// ---------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int SER_DATA_W = 32'sd4;
    localparam int SER_DIV    = 32'sd2;

    // Even parity bit: set when the word holds an odd number of ones.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/clk_en_gen.sv
// ---------------------------------------------------------------------------
// clk_en_gen: free-running prescaler producing a registered one-cycle tick
// every DIV clk cycles. DIV=1 gives a tick on every cycle after reset.
// Ports:
//   clk    in  : system clock, rising edge
//   rst    in  : asynchronous active-low reset
//   clk_en out : registered tick, high while the count sits at DIV-1
// ---------------------------------------------------------------------------
module clk_en_gen
    import ser_pkg::*;
#(
    parameter int DIV = SER_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic clk_en
);

    localparam int            CW      = (DIV > 32'sd1) ? $clog2(DIV) : 32'sd1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 32'sd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          clk_en_q;
    logic          clk_en_d;

    // Next count with wrap; the tick flop is aligned with the count it reports.
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1'b1);
        end
        clk_en_d = (cnt_d == CNT_MAX);
    end

    // Prescaler state and registered tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            clk_en_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            clk_en_q <= clk_en_d;
        end
    end

    assign clk_en = clk_en_q;

endmodule

// File: rtl/ser_tx_stage.sv
// ---------------------------------------------------------------------------
// ser_tx_stage: accepts parallel words over valid/ready, buffers one word and
// serialises it onto ser_out, one bit per clk_en tick, framed by ser_en.
// Build option: define SER_TX_PARITY_EN to append an even-parity bit after
// the data bits of every word (DATA_W+1 ticks per word).
// Ports:
//   clk      in  : system clock, rising edge
//   rst      in  : asynchronous active-low reset
//   in_data  in  : word to transmit (DATA_W bits)
//   in_valid in  : in_data is valid
//   in_ready out : holding buffer empty; accept on in_valid & in_ready
//   clk_en   out : shared tick, one cycle every DIV cycles
//   ser_out  out : current serial bit
//   ser_en   out : ser_out carries a valid bit
//   busy     out : a word is in the shifter or the buffer
//   done     out : pulse on the tick consuming the last bit of a word
// ---------------------------------------------------------------------------
module ser_tx_stage
    import ser_pkg::*;
#(
    parameter int DATA_W    = SER_DATA_W,
    parameter int DIV       = SER_DIV,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              clk_en,
    output logic              ser_out,
    output logic              ser_en,
    output logic              busy,
    output logic              done
);

`ifdef SER_TX_PARITY_EN
    localparam int SH_W = DATA_W + 32'sd1;
`else
    localparam int SH_W = DATA_W;
`endif
    localparam int              BC_W    = (SH_W > 32'sd1) ? $clog2(SH_W) : 32'sd1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(SH_W - 32'sd1);

    // Shifter image of a word; the parity bit sits where it leaves last.
    function automatic logic [SH_W-1:0] load_word(input logic [DATA_W-1:0] w);
`ifdef SER_TX_PARITY_EN
        logic p;
        p = even_parity(64'(w));
        if (MSB_FIRST) begin
            return {w, p};
        end else begin
            return {p, w};
        end
`else
        return w;
`endif
    endfunction

    function automatic logic head_bit(input logic [SH_W-1:0] v);
        if (MSB_FIRST) begin
            return v[SH_W-1];
        end else begin
            return v[0];
        end
    endfunction

    function automatic logic [SH_W-1:0] advance(input logic [SH_W-1:0] v);
        if (MSB_FIRST) begin
            return v << 1'b1;
        end else begin
            return v >> 1'b1;
        end
    endfunction

    state_e            state_q, state_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic              in_ready_q, in_ready_d;
    logic              ser_en_q, ser_en_d;
    logic              ser_out_q, ser_out_d;
    logic              busy_q, busy_d;
    logic              done_arm_q, done_arm_d;
    logic              clk_en_s;
    logic              accept_s;
    logic              load_s;

    clk_en_gen #(
        .DIV (DIV)
    ) u_clk_en_gen (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en_s)
    );

    // Handshake, buffer, shifter FSM and next values of the output flops.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        load_s   = 1'b0;
        accept_s = in_valid & in_ready_q;

        case (state_q)
            ST_IDLE: begin
                // Loading does not wait for a tick.
                if (buf_full_q) begin
                    shift_d  = load_word(buf_q);
                    bitcnt_d = BC_LAST;
                    load_s   = 1'b1;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (clk_en_s) begin
                    if (bitcnt_q != '0) begin
                        shift_d  = advance(shift_q);
                        bitcnt_d = bitcnt_q - BC_W'(1'b1);
                    end else if (buf_full_q) begin
                        // Reload straight away so the next word follows with no gap tick.
                        shift_d  = load_word(buf_q);
                        bitcnt_d = BC_LAST;
                        load_s   = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept and drain are exclusive: in_ready is low whenever the buffer is full.
        buf_d      = accept_s ? in_data : buf_q;
        buf_full_d = accept_s ? 1'b1 : (load_s ? 1'b0 : buf_full_q);

        in_ready_d = ~buf_full_d;
        busy_d     = (state_d == ST_SHIFT) | buf_full_d;
        ser_en_d   = (state_d == ST_SHIFT);
        ser_out_d  = (state_d == ST_SHIFT) ? head_bit(shift_d) : 1'b0;
        done_arm_d = (state_d == ST_SHIFT) && (bitcnt_d == '0);
    end

    // All state and output flops; reset discards any partial or buffered word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            in_ready_q <= 1'b0;
            ser_en_q   <= 1'b0;
            ser_out_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_arm_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            in_ready_q <= in_ready_d;
            ser_en_q   <= ser_en_d;
            ser_out_q  <= ser_out_d;
            busy_q     <= busy_d;
            done_arm_q <= done_arm_d;
        end
    end

    assign in_ready = in_ready_q;
    assign clk_en   = clk_en_s;
    assign ser_out  = ser_out_q;
    assign ser_en   = ser_en_q;
    assign busy     = busy_q;
    // done_arm_q marks the final bit; the registered tick picks the cycle it is consumed.
    assign done     = done_arm_q & clk_en_s;

endmodule

// File: doc/ser_tx_stage.md
Name: ser_tx_stage

Overview:
- Upstream feeder for the serial shift-register / counter stages of the datapath.
- Accepts parallel words over a valid/ready handshake and buffers one word.
- Generates the shared clk_en tick and serialises each word onto ser_out, with ser_en framing.
- The downstream shift register captures one bit per cycle where ser_en & clk_en are both high.

Parameters:
- DATA_W, 4: bits per word; minimum 1.
- DIV, 2: clk_en period in clk cycles; minimum 1, where 1 means clk_en is constantly high.
- MSB_FIRST, 1: 1 sends in_data[DATA_W-1] first; 0 sends bit 0 first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  holding buffer empty; a word is accepted when in_valid & in_ready.
- clk_en  output  1  one-cycle tick every DIV cycles; shared with downstream stages.
- ser_out  output  1  current serial bit.
- ser_en  output  1  ser_out carries a valid bit.
- busy  output  1  a word is in the shifter or the buffer.
- done  output  1  one-cycle pulse on the tick that consumes the last bit of a word.

Behaviour:
- Reset (rst low), applied immediately and asynchronously:
  - All flops clear: prescaler=0, buf_full=0, state=IDLE.
  - clk_en, ser_out, ser_en, busy and done are all 0.
  - in_ready is forced 0 while rst is low, and is 1 on the first cycle after release.
- Prescaler:
  - Free-running counter 0..DIV-1, width $clog2(DIV) with a minimum of 1.
  - clk_en=1 when count==DIV-1 and wraps to 0. It is registered and runs regardless of state.
- Holding buffer:
  - in_ready = ~buf_full, with no combinational path from in_valid.
  - On accept, in_data is captured and buf_full is set the next cycle.
  - When the buffer drains, in_ready rises the cycle after the drain, never in the same cycle.
- FSM, states IDLE and SHIFT:
  - IDLE: if buf_full, then on the next edge load the shifter from the buffer, set bitcnt=DATA_W-1, clear buf_full and go to SHIFT. The load does not wait for clk_en.
  - SHIFT: ser_en=1, and ser_out is the shifter MSB (LSB when MSB_FIRST=0). Nothing changes on cycles without clk_en.
  - SHIFT with clk_en and bitcnt!=0: shift by one and decrement bitcnt.
  - SHIFT with clk_en and bitcnt==0: pulse done that cycle. If buf_full, reload directly and stay in SHIFT, so the next word follows with no gap tick. Otherwise go to IDLE.
- Outputs:
  - ser_en, ser_out and done are driven from registered state and are glitch-free.
  - busy = (state==SHIFT) | buf_full.
- Latency and throughput:
  - Accept at edge N gives buf_full at N+1 and ser_en at N+2.
  - The first bit is consumed on the first clk_en at or after N+2.
  - Back-to-back words sustain one bit per tick.
- Boundaries:
  - An accept in the same cycle as a reload-from-buffer is not possible, because in_ready is low while buf_full.
  - in_valid held high with in_ready low: the word is not taken and the bench must hold it.
  - DIV=1: one bit per clk.
  - Reset mid-word: the partial word and buffered word are discarded, with no done pulse.

Optional Feature:
- Macro SER_TX_PARITY_EN.
- Defined: after the last data bit, one extra even-parity bit (XOR of the word) is sent with ser_en=1. There are DATA_W+1 ticks per word, bitcnt width grows accordingly, and done pulses on the parity tick.
- Undefined: exactly DATA_W ticks per word and no parity logic.

Decomposition:
- Shared package ser_pkg holds:
  - state encodings ST_IDLE=1'b0 and ST_SHIFT=1'b1.
  - default DATA_W and DIV constants, also used by the downstream shift register and counters.
- One natural sub-module: clk_en_gen (parameter DIV; ports clk, rst, clk_en). It is reused by other stages needing the same tick.

Test Plan:
1. Reset: hold rst low for 3 clks -> all outputs 0 and in_ready 0. Release -> in_ready=1 next cycle, and clk_en pulses every 2nd cycle (DIV=2).
2. Single word 4'b1011, MSB_FIRST=1 -> ser_out 1,0,1,1 on 4 consecutive clk_en ticks with ser_en=1; done on the 4th tick. A downstream 4-bit shift register then holds 4'b1011, and ser_en/busy drop afterwards.
3. Back-to-back 4'hA then 4'h5 with in_valid held -> 8 contiguous ticks with ser_en never low. Output is 1,0,1,0,0,1,0,1, with two done pulses. in_ready is low while the buffer is full.
4. MSB_FIRST=0 with 4'b0001 -> ser_out 1,0,0,0. DIV=1 variant -> one bit per clk.
5. Reset mid-word: rst low after 2 bits of 4'hC with 4'h3 buffered -> ser_en=0 immediately and no done pulse. After release, a new word 4'h9 sends 1,0,0,1 cleanly.
6. SER_TX_PARITY_EN defined, 4'b0111 -> 0,1,1,1 then parity 1 over 5 ticks; done on the 5th tick.
